// File: rtl/glyph_renderer_if.sv
// Bundle of the request, font ROM and pixel-stream signals of the glyph renderer.
// Request and pixel channels: a beat moves on a rising edge where valid && ready; a raised valid and its payload hold until that edge.
interface glyph_renderer_if #(
   parameter int PIX_W = 16
);
   logic             char_valid;
   logic             char_ready;
   logic [7:0]       char_code;
   logic [PIX_W-1:0] fg;
   logic [PIX_W-1:0] bg;
   logic [10:0]      font_addr;
   logic [7:0]       font_data;
   logic             pix_valid;
   logic             pix_ready;
   logic [PIX_W-1:0] pix_data;
   logic             pix_last;
   logic             busy;
   logic [1:0]       state_dbg;

   modport slave (
      input  char_valid, char_code, fg, bg, font_data, pix_ready,
      output char_ready, font_addr, pix_valid, pix_data, pix_last, busy, state_dbg
   );

   modport master (
      output char_valid, char_code, fg, bg, font_data, pix_ready,
      input  char_ready, font_addr, pix_valid, pix_data, pix_last, busy, state_dbg
   );
endinterface

// File: rtl/glyph_renderer.sv
// Fetches an 8x8 glyph (8 column bytes) from the font ROM, then streams 64 fg/bg pixels.
module glyph_renderer #(
   parameter int PIX_W     = 16,
   parameter bit COL_MAJOR = 1'b0
) (
   input  logic            clk,
   input  logic            resetn,
   glyph_renderer_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EMIT = 2'd2} state_t;

   state_t           state, state_n;
   logic [7:0]       code_q;
   logic [PIX_W-1:0] fg_q, bg_q;
   logic [2:0]       col;
   logic             phase;
   logic [63:0]      glyph;
   logic [5:0]       p;

   // glyph bit {c, r} holds row r of column c.
   function automatic logic [PIX_W-1:0] pick(input logic [63:0] g, input logic [5:0] idx,
                                             input logic [PIX_W-1:0] f, input logic [PIX_W-1:0] b);
      logic [2:0] r, c;
      if (COL_MAJOR) begin
         c = idx[5:3];
         r = idx[2:0];
      end else begin
         r = idx[5:3];
         c = idx[2:0];
      end
      return g[{c, r}] ? f : b;
   endfunction

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.char_valid) state_n = FETCH;
         FETCH:   if (phase && col == 3'd7) state_n = EMIT;
         EMIT:    if (bus.pix_ready && p == 6'd63) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   assign bus.char_ready = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.state_dbg  = state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         code_q        <= '0;
         fg_q          <= '0;
         bg_q          <= '0;
         col           <= '0;
         phase         <= 1'b0;
         glyph         <= '0;
         p             <= '0;
         bus.font_addr <= '0;
         bus.pix_valid <= 1'b0;
         bus.pix_data  <= '0;
         bus.pix_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.char_valid) begin
                  code_q        <= bus.char_code;
                  fg_q          <= bus.fg;
                  bg_q          <= bus.bg;
                  col           <= 3'd0;
                  phase         <= 1'b0;
                  bus.font_addr <= {bus.char_code, 3'd0};
               end
            end
            FETCH: begin
               // ROM data is registered, so the address stays put for both phases of a column.
               phase <= ~phase;
               if (phase) begin
                  glyph[{col, 3'b000} +: 8] <= bus.font_data;
                  col <= col + 3'd1;
                  if (col != 3'd7) begin
                     bus.font_addr <= {code_q, col + 3'd1};
                  end else begin
                     // Pixel 0 always lies in column 0, already in the buffer.
                     p             <= 6'd0;
                     bus.pix_valid <= 1'b1;
                     bus.pix_data  <= pick(glyph, 6'd0, fg_q, bg_q);
                     bus.pix_last  <= 1'b0;
                  end
               end
            end
            EMIT: begin
               if (bus.pix_ready) begin
                  if (p == 6'd63) begin
                     bus.pix_valid <= 1'b0;
                     bus.pix_last  <= 1'b0;
                  end else begin
                     p            <= p + 6'd1;
                     bus.pix_data <= pick(glyph, p + 6'd1, fg_q, bg_q);
                     bus.pix_last <= (p == 6'd62);
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_glyph_renderer.sv
// Randomized bench for glyph_renderer: font ROM model, glyph-level pixel model and scoreboard.
module tb_glyph_renderer;
   localparam int PIX_W = 16;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   glyph_renderer_if #(.PIX_W(PIX_W)) ifr ();
   glyph_renderer_if #(.PIX_W(PIX_W)) ifc ();

   glyph_renderer #(.PIX_W(PIX_W), .COL_MAJOR(1'b0)) dut_r (.clk(clk), .resetn(resetn), .bus(ifr));
   glyph_renderer #(.PIX_W(PIX_W), .COL_MAJOR(1'b1)) dut_c (.clk(clk), .resetn(resetn), .bus(ifc));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Font ROM: '!' and ' ' fixed, every other code gets a hashed pattern.
   function automatic logic [7:0] rom_byte(input logic [10:0] a);
      logic [7:0] h;
      h = (a[7:0] * 8'h9D) ^ {a[10:8], 5'b10110} ^ 8'h5A;
      if (a[10:3] == 8'h20) return 8'h00;
      if (a[10:3] == 8'h21) begin
         case (a[2:0])
            3'd1, 3'd4: return 8'h06;
            3'd2, 3'd3: return 8'h5F;
            default:    return 8'h00;
         endcase
      end
      return h;
   endfunction

   always @(posedge clk) ifr.font_data <= rom_byte(ifr.font_addr);
   always @(posedge clk) ifc.font_data <= rom_byte(ifc.font_addr);

   // Pixel k of a glyph: pick row/column from k, then test that bit of the ROM column byte.
   function automatic logic [PIX_W-1:0] model_pix(input logic [7:0] code, input logic [PIX_W-1:0] f,
                                                  input logic [PIX_W-1:0] b, input int k, input bit colmaj);
      int r, c;
      logic [7:0] colbyte;
      r = colmaj ? k % 8 : k / 8;
      c = colmaj ? k / 8 : k % 8;
      colbyte = rom_byte({code, 3'(c)});
      return colbyte[r] ? f : b;
   endfunction

   bit rand_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      ifr.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Scoreboard for the row-major instance.
   logic [PIX_W:0]   exp_q[$];
   int               acc_q[$];
   bit               exp_busy = 1'b0;
   bit               acc_on = 1'b0;
   int               acc_cyc;
   logic [7:0]       acc_code;
   bit               prev_stall = 1'b0;
   logic [PIX_W-1:0] prev_data;
   logic             prev_last;
   logic [PIX_W-1:0] got_r[64];
   int               nr = 0;
   logic [PIX_W-1:0] got_c[64];
   int               nc = 0;

   always @(negedge clk) begin
      logic [PIX_W:0] e;
      int t;
      bit clr;
      clr = 1'b0;
      if (!resetn) begin
         exp_q.delete();
         exp_busy   = 1'b0;
         acc_on     = 1'b0;
         prev_stall = 1'b0;
         chk("reset_pix_valid", ifr.pix_valid, 0);
         chk("reset_busy", ifr.busy, 0);
         chk("reset_char_ready", ifr.char_ready, 1);
         chk("reset_pix_last", ifr.pix_last, 0);
      end else begin
         chk("busy", ifr.busy, exp_busy);
         chk("char_ready", ifr.char_ready, !exp_busy);
         if (!exp_busy) chk("idle_pix_valid", ifr.pix_valid, 0);
         if (acc_on) begin
            t = cyc - acc_cyc;
            if (t >= 1 && t <= 16) chk("font_addr", ifr.font_addr, {acc_code, 3'((t - 1) / 2)});
            if (t >= 1 && t <= 17) chk("first_valid_latency", ifr.pix_valid, (t == 17));
            if (t >= 17) acc_on = 1'b0;
         end
         if (prev_stall) begin
            chk("stall_valid", ifr.pix_valid, 1);
            chk("stall_data", ifr.pix_data, prev_data);
            chk("stall_last", ifr.pix_last, prev_last);
         end
         if (ifr.pix_valid && ifr.pix_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_pixel", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pix_data", ifr.pix_data, e[PIX_W-1:0]);
               chk("pix_last", ifr.pix_last, e[PIX_W]);
               if (nr < 64) got_r[nr] = ifr.pix_data;
               nr++;
               if (e[PIX_W]) clr = 1'b1;
            end
         end
         prev_stall = ifr.pix_valid && !ifr.pix_ready;
         prev_data  = ifr.pix_data;
         prev_last  = ifr.pix_last;
         if (clr) exp_busy = 1'b0;
         if (ifr.char_valid && ifr.char_ready) begin
            for (int k = 0; k < 64; k++)
               exp_q.push_back({1'(k == 63), model_pix(ifr.char_code, ifr.fg, ifr.bg, k, 1'b0)});
            exp_busy = 1'b1;
            acc_on   = 1'b1;
            acc_cyc  = cyc;
            acc_code = ifr.char_code;
            acc_q.push_back(cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (resetn && ifc.pix_valid && ifc.pix_ready) begin
         if (nc < 64) got_c[nc] = ifc.pix_data;
         nc++;
      end
   end

   task automatic send_r(input logic [7:0] code, input logic [PIX_W-1:0] f, input logic [PIX_W-1:0] b);
      bit acc;
      acc = 1'b0;
      @(posedge clk); #1;
      ifr.char_valid = 1'b1;
      ifr.char_code  = code;
      ifr.fg         = f;
      ifr.bg         = b;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         if (ifr.char_ready) acc = 1'b1;
      end
      @(posedge clk); #1;
      ifr.char_valid = 1'b0;
      ifr.char_code  = 8'($urandom);
      ifr.fg         = PIX_W'($urandom);
      ifr.bg         = PIX_W'($urandom);
      chk("accept_timeout", acc, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!exp_busy) break;
      end
      chk("done_timeout", exp_busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PIX_W-1:0] save_r[64];
      logic [PIX_W-1:0] row0[8];
      logic [PIX_W-1:0] col2[8];
      logic [PIX_W-1:0] f, b;
      bit acc;
      row0 = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      col2 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};

      resetn = 1'b0;
      ifr.char_valid = 1'b0; ifr.char_code = '0; ifr.fg = '0; ifr.bg = '0;
      ifc.char_valid = 1'b0; ifc.char_code = '0; ifc.fg = '0; ifc.bg = '0;
      ifc.pix_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("reset_pix_data", ifr.pix_data, 0);
      chk("reset_font_addr", ifr.font_addr, 0);
      repeat (20) @(negedge clk);

      // '!' with pix_ready held high
      nr = 0;
      send_r(8'h21, 16'hFFFF, 16'h0000);
      wait_done();
      chk("bang_count", nr, 64);
      for (int i = 0; i < 8; i++) chk("bang_row0_literal", got_r[i], row0[i]);
      for (int i = 56; i < 64; i++) chk("bang_row7_literal", got_r[i], 16'h0000);
      for (int i = 0; i < 64; i++) save_r[i] = got_r[i];

      // Same glyph under random backpressure
      rand_ready = 1'b1;
      nr = 0;
      send_r(8'h21, 16'hFFFF, 16'h0000);
      wait_done();
      chk("bp_count", nr, 64);
      for (int i = 0; i < 64; i++) chk("bp_same_sequence", got_r[i], save_r[i]);

      // Random glyphs, random colours, random backpressure
      for (int g = 0; g < 4; g++) begin
         nr = 0;
         send_r(8'($urandom_range(0, 255)), PIX_W'($urandom), PIX_W'($urandom));
         wait_done();
         chk("rand_count", nr, 64);
      end
      nr = 0;
      send_r(8'hFF, PIX_W'($urandom), PIX_W'($urandom));
      wait_done();
      rand_ready = 1'b0;

      // Back-to-back: char_valid held across two requests
      acc_q.delete();
      @(posedge clk); #1;
      ifr.char_valid = 1'b1; ifr.char_code = 8'h41;
      ifr.fg = PIX_W'($urandom); ifr.bg = PIX_W'($urandom);
      acc = 1'b0;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         if (ifr.char_ready) acc = 1'b1;
      end
      @(posedge clk); #1;
      ifr.char_code = 8'h42;
      ifr.fg = PIX_W'($urandom); ifr.bg = PIX_W'($urandom);
      acc = 1'b0;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         if (ifr.char_ready) acc = 1'b1;
      end
      @(posedge clk); #1;
      ifr.char_valid = 1'b0;
      chk("b2b_accept", acc, 1);
      wait_done();
      chk("b2b_accepts", acc_q.size(), 2);
      if (acc_q.size() == 2) chk("b2b_period", acc_q[1] - acc_q[0], 81);

      // Column-major instance with '!'
      nc = 0;
      @(posedge clk); #1;
      ifc.char_valid = 1'b1; ifc.char_code = 8'h21; ifc.fg = 16'hFFFF; ifc.bg = 16'h0000;
      acc = 1'b0;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         if (ifc.char_ready) acc = 1'b1;
      end
      @(posedge clk); #1;
      ifc.char_valid = 1'b0;
      for (int i = 0; i < 300 && nc < 64; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("cm_count", nc, 64);
      chk("cm_idle_valid", ifc.pix_valid, 0);
      for (int i = 0; i < 64; i++) chk("cm_model", got_c[i], model_pix(8'h21, 16'hFFFF, 16'h0000, i, 1'b1));
      for (int i = 0; i < 8; i++) chk("cm_col0_literal", got_c[i], 16'h0000);
      for (int i = 0; i < 8; i++) chk("cm_col2_literal", got_c[16 + i], col2[i]);

      // Reset in the middle of EMIT
      nr = 0;
      send_r(8'h21, 16'hFFFF, 16'h0000);
      for (int i = 0; i < 300 && nr < 30; i++) @(negedge clk);
      chk("mid_reset_reached", nr >= 30, 1);
      @(posedge clk); #2;
      resetn = 1'b0;
      #1;
      chk("async_pix_valid_drop", ifr.pix_valid, 0);
      chk("async_pix_last_drop", ifr.pix_last, 0);
      chk("async_busy_drop", ifr.busy, 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("post_reset_char_ready", ifr.char_ready, 1);
      f = PIX_W'($urandom); b = PIX_W'($urandom);
      nr = 0;
      send_r(8'h20, f, b);
      wait_done();
      chk("space_count", nr, 64);
      for (int i = 0; i < 64; i++) chk("space_all_bg", got_r[i], b);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/glyph_renderer.md
Name: glyph_renderer

Overview:
- Consumer side of the 8x8 font ROM interface.
- Accepts one character code plus foreground/background colours over a valid/ready handshake.
- Fetches the glyph's 8 column bytes from the font ROM into a local buffer, then streams 64 colour pixels in raster order (row-major) to a display pixel sink over valid/ready.
- Sits between the text/console logic and the OLED/VGA pixel pipeline.

Parameters:
- PIX_W, 16, width of colour words and of output pixels (RGB565 by default).
- COL_MAJOR, 0, when 1, emit pixels column-major (column 0 rows 0..7, then column 1, ...) instead of row-major.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- char_valid  in  1  character request valid.
- char_ready  out  1  renderer can accept a request (IDLE only).
- char_code  in  8  character code.
- fg  in  PIX_W  colour for set glyph bits.
- bg  in  PIX_W  colour for clear glyph bits.
- font_addr  out  11  font ROM address = {char_code, col[2:0]}.
- font_data  in  8  font ROM byte: bit r = row r of the column, bit 0 = top row.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  sink accepts pixel.
- pix_data  out  PIX_W  pixel colour.
- pix_last  out  1  high with the 64th pixel of the glyph.
- busy  out  1  high in FETCH or EMIT.

Behaviour:
- Reset (async, resetn=0): state=IDLE, char_ready=1, pix_valid=0, pix_last=0, pix_data=0, font_addr=0, busy=0, glyph buffer cleared, counters=0.
- IDLE:
  - char_ready=1.
  - On char_valid&&char_ready: latch char_code, fg, bg; col=0; phase=0; go to FETCH.
- FETCH:
  - font_addr={code, col}, held 2 cycles per column. The ROM has 1-cycle registered read and its output byte select follows the live address, so the address must stay stable through the data cycle.
  - phase 0: address presented.
  - phase 1: same address; font_data sampled into buffer column col at the clock edge ending phase 1.
  - col increments after phase 1. After col 7 is sampled, go to EMIT with pixel index p=0.
  - FETCH takes exactly 16 cycles.
  - char_ready=0; font_addr holds its last value outside FETCH.
- EMIT:
  - pix_valid=1.
  - pix_data: row-major (COL_MAJOR=0): row r=p[5:3], col c=p[2:0]. Column-major: c=p[5:3], r=p[2:0]. Output is fg if buffer[c][r]==1, else bg.
  - pix_data, pix_last and pix_valid are registered outputs and must remain stable while pix_valid && !pix_ready (AXI-style; no retraction).
  - Transfer occurs on pix_valid&&pix_ready; p increments.
  - pix_last=1 exactly when p==63.
  - On the transfer of p==63: pix_valid=0 next cycle, state=IDLE, char_ready=1.
- Throughput:
  - With pix_ready stuck at 1: 64 consecutive pixel cycles.
  - Request acceptance to first pix_valid: 17 cycles (1 accept + 16 fetch).
  - Glyph-to-glyph minimum period: 1 + 16 + 64 = 81 cycles.
- char_valid during FETCH/EMIT: ignored (not accepted; char_ready=0). The requester holds it.
- fg/bg/char_code changes after acceptance have no effect on the glyph in flight.
- Full 8-bit code range valid; code 0xFF addresses 0x7F8..0x7FF (no wrap logic required).
- resetn asserted mid-FETCH or mid-EMIT: immediate return to reset values; the partial glyph is discarded and no pix_last is issued.
- busy = (state != IDLE).

Test Plan:
- Reset then idle: resetn low 3 cycles with pix_ready=1 -> char_ready=1, pix_valid=0, busy=0; no output activity for 20 cycles.
- Glyph '!' (code 0x21) with real font ROM, fg=0xFFFF, bg=0x0000, pix_ready=1 -> font_addr steps 0x108..0x10F, each held 2 cycles. First pix_valid 17 cycles after acceptance. Row 0 = 0000,0000,FFFF,FFFF,0000,0000,0000,0000. Row 7 all 0x0000. pix_last on pixel 63 only.
- Backpressure: same glyph, pix_ready toggled pseudo-randomly (~50%) -> pix_data/pix_last stable while stalled; the same 64-pixel sequence as the unstalled run; exactly 64 transfers.
- Back-to-back requests: char_valid held with codes 0x41 then 0x42 -> second accepted only in the cycle after the first glyph's pix_last transfer; second glyph pixels are correct; char_ready=0 throughout busy.
- COL_MAJOR=1 with code 0x21 -> pixels 0..7 all bg (column 0 = 0x00); pixels 16..23 = F,F,F,F,F,bg,F,bg for column 2 (0x5F, bit0 first).
- Reset mid-EMIT: assert resetn at pixel 30 -> pix_valid drops asynchronously, char_ready=1 after release; a new request for 0x20 streams 64 bg pixels.
